divseq32: RTL and testbench
===========================

DIVSEQ32 -- requirements
Module: divseq32

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a division; sampled on rising clk.
REQ-005 dividend  input  32  numerator; captured on the edge that accepts start.
REQ-006 divisor  input  32  denominator; captured on the edge that accepts start.
REQ-007 busy  output  1  high while an iteration sequence is running.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 quot  output  32  quotient; valid from done onward, held until the next accepted start.
REQ-010 rem  output  32  remainder; same validity as quot.
REQ-011 div0  output  1  set with done when the captured divisor was zero.

Function
REQ-012 The block SHALL have a state machine with states IDLE, RUN and DONE:
- IDLE -> RUN on start with divisor != 0.
- IDLE -> DONE on start with divisor == 0.
- RUN -> DONE after the 32nd iteration.
- DONE -> IDLE unconditionally, or DONE -> RUN/DONE if start is high in DONE.
REQ-013 The block SHALL ignore start while in RUN; the captured operands SHALL NOT change.
REQ-014 The block SHALL perform one restoring-division iteration per clk in RUN, 32 iterations total, MSB of dividend first.
REQ-015 Each iteration SHALL form a trial subtraction through one instance of addsub32 (sub=1):
- a = {R[30:0], next dividend bit}, where R is the partial remainder; b = divisor.
REQ-016 An iteration SHALL succeed when R[31] (the bit shifted out) is 1 or addsub32 co is 1.
- On success: quotient bit = 1 and R = res.
- Otherwise: quotient bit = 0 and R = the shifted value.
REQ-017 busy SHALL equal (state == RUN).
REQ-018 done SHALL be high for exactly the one cycle the FSM is in DONE.
REQ-019 For a non-zero divisor, done SHALL first be high after the 33rd rising edge counting the start-accepting edge as edge 1 (latency 33).
REQ-020 For divisor == 0, the block SHALL assert done and div0 after edge 1, with quot = 32'hFFFFFFFF and rem = dividend.
REQ-021 div0 SHALL be cleared by the next accepted start.
REQ-022 quot and rem SHALL update only on entry to DONE, never during RUN.
REQ-023 Back-to-back operation: start high during the DONE cycle SHALL be accepted with no idle gap.

Reset
REQ-024 rst_n low SHALL, asynchronously and at any point including mid-RUN:
- force IDLE;
- set busy=0, done=0, div0=0, quot=0, rem=0;
- clear the iteration counter and partial remainder.
REQ-025 An in-flight division interrupted by reset SHALL be discarded; no done pulse follows reset release.

Configuration
REQ-026 Macro DIVSEQ32_SIGNED_EN SHALL control signed-division support:
- Defined: an extra 1-bit input sgn, captured with start, is added. When sgn=1:
  - operands are two's complement, converted to magnitudes at capture;
  - quot is negated if the operand signs differ (truncation toward zero);
  - rem takes the sign of dividend;
  - 0x80000000 / 0xFFFFFFFF yields quot=0x80000000, rem=0;
  - latency is unchanged.
- Undefined: there is no sgn port and division is always unsigned.

Verification
REQ-027 dividend=100, divisor=7, start 1 cycle -> busy for 32 cycles, done at edge 33, quot=14, rem=2, div0=0.
REQ-028 dividend=32'hFFFFFFFE, divisor=32'h80000001 -> quot=1, rem=32'h7FFFFFFD (exercises the R[31] success path).
REQ-029 dividend=5, divisor=0 -> done and div0 after edge 1, quot=32'hFFFFFFFF, rem=5.
REQ-030 Second start pulse at cycle 10 of a 100/7 run with different operands -> ignored, result still 14/2; a start in the DONE cycle of 32'hFFFFFFFF/1 -> next result quot=32'hFFFFFFFF, rem=0 at 33 edges later.
REQ-031 rst_n low for 1 cycle at RUN cycle 12 -> outputs 0 immediately, state IDLE, no done afterward.
REQ-032 With DIVSEQ32_SIGNED_EN, sgn=1, dividend=-7, divisor=2 -> quot=32'hFFFFFFFD, rem=32'hFFFFFFFF.

Source files
------------

// File: rtl/divseq32_if.sv
// rtl/divseq32_if.sv - handshake/operand/result bundle for divseq32 (sgn present with DIVSEQ32_SIGNED_EN)
interface divseq32_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIVSEQ32_SIGNED_EN
    logic        sgn;
`endif
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div0;

`ifdef DIVSEQ32_SIGNED_EN
    modport master (output start, dividend, divisor, sgn,
                    input  busy, done, quot, rem, div0);
    modport slave  (input  start, dividend, divisor, sgn,
                    output busy, done, quot, rem, div0);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quot, rem, div0);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quot, rem, div0);
`endif
endinterface

// File: rtl/divseq32.sv
// rtl/divseq32.sv - 32-cycle restoring divider; DIVSEQ32_SIGNED_EN adds signed operands via sgn
module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] res,
    output logic        co
);
    assign {co, res} = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
endmodule

module divseq32 (
    input  logic       clk,
    input  logic       rst_n,
    divseq32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] r;
    logic [31:0] qs;
    logic [31:0] dvsr;
    logic [31:0] quot_q, rem_q;
    logic        div0_q;
    logic        neg_q, neg_r;

    logic        sgn_in;
    logic        accept;
    logic        last;
    logic [31:0] dvd_mag, dvs_mag;
    logic [31:0] shifted, diff, r_nxt, q_nxt, q_fin, r_fin;
    logic        co, succ;

`ifdef DIVSEQ32_SIGNED_EN
    assign sgn_in = bus.sgn;
`else
    assign sgn_in = 1'b0;
`endif

    assign accept  = (state != RUN) && bus.start;
    assign last    = (state == RUN) && (cnt == 5'd31);
    assign dvd_mag = (sgn_in && bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
    assign dvs_mag = (sgn_in && bus.divisor[31])  ? (~bus.divisor + 32'd1)  : bus.divisor;

    // qs shifts the dividend out at the top while quotient bits enter at the bottom
    assign shifted = {r[30:0], qs[31]};

    addsub32 u_addsub (
        .a   (shifted),
        .b   (dvsr),
        .sub (1'b1),
        .res (diff),
        .co  (co)
    );

    // r[31] set means the shifted value exceeds 32 bits, so it always covers the divisor
    assign succ  = r[31] | co;
    assign r_nxt = succ ? diff : shifted;
    assign q_nxt = {qs[30:0], succ};
    assign q_fin = neg_q ? (~q_nxt + 32'd1) : q_nxt;
    assign r_fin = neg_r ? (~r_nxt + 32'd1) : r_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start)
                    state_nxt = (bus.divisor == 32'd0) ? DONE : RUN;
                else
                    state_nxt = IDLE;
            end
            RUN: begin
                if (cnt == 5'd31)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            r      <= 32'd0;
            qs     <= 32'd0;
            dvsr   <= 32'd0;
            quot_q <= 32'd0;
            rem_q  <= 32'd0;
            div0_q <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            cnt    <= 5'd0;
            r      <= 32'd0;
            qs     <= dvd_mag;
            dvsr   <= dvs_mag;
            div0_q <= (bus.divisor == 32'd0);
            neg_q  <= sgn_in && (bus.dividend[31] ^ bus.divisor[31]);
            neg_r  <= sgn_in && bus.dividend[31];
            if (bus.divisor == 32'd0) begin
                quot_q <= 32'hFFFF_FFFF;
                rem_q  <= bus.dividend;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            r   <= r_nxt;
            qs  <= q_nxt;
            if (last) begin
                quot_q <= q_fin;
                rem_q  <= r_fin;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.div0 = div0_q;
endmodule

// File: tb/tb_divseq32.sv
// tb/tb_divseq32.sv - randomized self-checking bench for divseq32 against an arithmetic model
module tb_divseq32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    divseq32_if bus ();

    divseq32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic cur_sgn;
`ifdef DIVSEQ32_SIGNED_EN
    assign cur_sgn = bus.sgn;
`else
    assign cur_sgn = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mq(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0)                                   return 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        if (s)                                            return 32'($signed(a) / $signed(b));
        return a / b;
    endfunction

    function automatic logic [31:0] mr(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0)                                   return a;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        if (s)                                            return 32'($signed(a) % $signed(b));
        return a % b;
    endfunction

    // Model: an accepted division stays busy for 32 edges, then shows its result for one cycle
    int          m_left;
    logic        m_done, m_div0;
    logic [31:0] m_quot, m_rem, p_quot, p_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_div0 <= 1'b0;
            m_quot <= 32'd0;
            m_rem  <= 32'd0;
            p_quot <= 32'd0;
            p_rem  <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_quot <= p_quot;
                    m_rem  <= p_rem;
                end
            end else if (bus.start) begin
                m_div0 <= (bus.divisor == 32'd0);
                if (bus.divisor == 32'd0) begin
                    m_done <= 1'b1;
                    m_quot <= 32'hFFFF_FFFF;
                    m_rem  <= bus.dividend;
                end else begin
                    m_left <= 32;
                    p_quot <= mq(bus.dividend, bus.divisor, cur_sgn);
                    p_rem  <= mr(bus.dividend, bus.divisor, cur_sgn);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, bus.busy}, {31'd0, m_left > 0});
        chk("done", {31'd0, bus.done}, {31'd0, m_done});
        chk("div0", {31'd0, bus.div0}, {31'd0, m_div0});
        chk("quot", bus.quot, m_quot);
        chk("rem",  bus.rem,  m_rem);
    end

    // Caller sits 1ns after an edge; start is held across exactly one edge
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIVSEQ32_SIGNED_EN
        bus.sgn      = s;
`else
        if (s) $display("signed request ignored in unsigned build");
`endif
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int inj_at, input int rst_at, output int lat);
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (lat == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", {31'd0, bus.busy}, 32'd0);
                chk("rst_done", {31'd0, bus.done}, 32'd0);
                chk("rst_div0", {31'd0, bus.div0}, 32'd0);
                chk("rst_quot", bus.quot, 32'd0);
                chk("rst_rem",  bus.rem,  32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk); #1;
                    chk("no_done_after_rst", {31'd0, bus.done}, 32'd0);
                end
                lat = -1;
                return;
            end
            if (lat == inj_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd999;
                bus.divisor  = 32'd3;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        chk("done_timeout", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        @(posedge clk); #1;
        pulse_start(a, b, s);
        wait_done(-1, -1, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] a, b;
        logic        s;

        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
`ifdef DIVSEQ32_SIGNED_EN
        bus.sgn      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_quot", bus.quot, 32'd0);
        chk("reset_rem",  bus.rem,  32'd0);
        rst_n = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, lat);
        chk("lat_100_7",  lat, 32'd33);
        chk("quot_100_7", bus.quot, 32'd14);
        chk("rem_100_7",  bus.rem,  32'd2);
        chk("div0_100_7", {31'd0, bus.div0}, 32'd0);

        run_div(32'hFFFF_FFFE, 32'h8000_0001, 1'b0, lat);
        chk("quot_r31", bus.quot, 32'd1);
        chk("rem_r31",  bus.rem,  32'h7FFF_FFFD);

        run_div(32'd5, 32'd0, 1'b0, lat);
        chk("lat_div0",  lat, 32'd1);
        chk("div0_flag", {31'd0, bus.div0}, 32'd1);
        chk("quot_div0", bus.quot, 32'hFFFF_FFFF);
        chk("rem_div0",  bus.rem,  32'd5);

        @(posedge clk); #1;
        pulse_start(32'd100, 32'd7, 1'b0);
        wait_done(10, -1, lat);
        chk("lat_ignored_start", lat, 32'd33);
        chk("quot_ignored_start", bus.quot, 32'd14);
        chk("rem_ignored_start",  bus.rem,  32'd2);

        pulse_start(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done(-1, -1, lat);
        chk("lat_b2b", lat, 32'd33);
        chk("quot_b2b", bus.quot, 32'hFFFF_FFFF);
        chk("rem_b2b",  bus.rem,  32'd0);

        @(posedge clk); #1;
        pulse_start(32'd12345, 32'd11, 1'b0);
        wait_done(-1, 12, lat);
        chk("lat_reset_abort", lat, 32'hFFFF_FFFF);

`ifdef DIVSEQ32_SIGNED_EN
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
        chk("quot_signed", bus.quot, 32'hFFFF_FFFD);
        chk("rem_signed",  bus.rem,  32'hFFFF_FFFF);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
        chk("quot_ovf", bus.quot, 32'h8000_0000);
        chk("rem_ovf",  bus.rem,  32'd0);
        chk("lat_ovf",  lat, 32'd33);
`endif

        for (int n = 0; n < 200; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            s = 1'b0;
`ifdef DIVSEQ32_SIGNED_EN
            s = $urandom_range(0, 1);
`endif
            if (bus.done && $urandom_range(0, 1) == 1) begin
                pulse_start(a, b, s);
            end else begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1;
                pulse_start(a, b, s);
            end
            wait_done(($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : -1, -1, lat);
            chk("lat_rand", lat, (b == 32'd0) ? 32'd1 : 32'd33);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
